// File: rtl/mul_share_arb_pkg.sv
// Shared definitions for the mul core arbiter slice.
package mul_share_pkg;

    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_TIMEOUT = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/mul_share_arb_if.sv
// Requester, response and core handshake bundle for mul_share_arb.
interface mul_share_arb_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ*DATA_W-1:0] req_c;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [NUM_REQ-1:0]        rsp_ready;
    logic [DATA_W-1:0]         rsp_data;
    logic                      rsp_err;
    logic                      core_start;
    logic                      core_ready;
    logic                      core_done;
    logic                      core_idle;
    logic [DATA_W-1:0]         core_a;
    logic [DATA_W-1:0]         core_b;
    logic [DATA_W-1:0]         core_c;
    logic [DATA_W-1:0]         core_return;

    // Arbiter side
    modport slave (
        input  req_valid, req_a, req_b, req_c, rsp_ready,
        input  core_ready, core_done, core_idle, core_return,
        output req_ready, rsp_valid, rsp_data, rsp_err,
        output core_start, core_a, core_b, core_c
    );

    // Clients and core side
    modport master (
        output req_valid, req_a, req_b, req_c, rsp_ready,
        output core_ready, core_done, core_idle, core_return,
        input  req_ready, rsp_valid, rsp_data, rsp_err,
        input  core_start, core_a, core_b, core_c
    );
endinterface

// File: rtl/mul_share_arb_rr_pick.sv
// Round-robin picker: first set request after last_grant, wrapping at N.
module rr_pick #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx
);
    logic             found;
    logic [IDX_W-1:0] cand;

    // Scan candidates in priority order starting just after last_grant
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned off = 1; off <= N; off++) begin
            cand = IDX_W'((32'(last_grant) + off) % N);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end
endmodule

// File: rtl/mul_share_arb.sv
// Round-robin sharing of a single mul core with watchdog timeout.
module mul_share_arb
    import mul_share_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic           ap_clk,
    input  logic           ap_rst_n,
    mul_share_arb_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    state_t             state_q, state_d;
    logic [ID_W-1:0]    last_grant_q, id_q, pick_idx;
    logic [NUM_REQ-1:0] pick_oh, req_ready, rsp_valid;
    logic [CNT_W-1:0]   cnt_q;
    logic               core_start, accept, take_done, take_tmo, rsp_hs, tmo_hit;
    logic [DATA_W-1:0]  core_a_q, core_b_q, core_c_q, rsp_data_q;
    logic               rsp_err_q;
    logic [DATA_W-1:0]  a_arr [NUM_REQ];
    logic [DATA_W-1:0]  b_arr [NUM_REQ];
    logic [DATA_W-1:0]  c_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign a_arr[g] = bus.req_a[g*DATA_W +: DATA_W];
        assign b_arr[g] = bus.req_b[g*DATA_W +: DATA_W];
        assign c_arr[g] = bus.req_c[g*DATA_W +: DATA_W];
    end

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_pick (
        .req        (bus.req_valid),
        .last_grant (last_grant_q),
        .grant      (pick_oh),
        .idx        (pick_idx)
    );

    assign tmo_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

    // State register
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // Next state, handshake outputs and datapath strobes
    always_comb begin
        state_d    = state_q;
        req_ready  = '0;
        rsp_valid  = '0;
        core_start = 1'b0;
        accept     = 1'b0;
        take_done  = 1'b0;
        take_tmo   = 1'b0;
        rsp_hs     = 1'b0;
        case (state_q)
            IDLE: begin
                if (ap_rst_n && bus.core_idle && (|pick_oh)) begin
                    req_ready = pick_oh;
                    accept    = 1'b1;
                    state_d   = START;
                end
            end
            START: begin
                core_start = 1'b1;
                if (bus.core_ready && bus.core_done) begin
                    take_done = 1'b1;
                    state_d   = RESP;
                end else if (tmo_hit) begin
                    take_tmo = 1'b1;
                    state_d  = RESP;
                end else if (bus.core_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.core_done) begin
                    take_done = 1'b1;
                    state_d   = RESP;
                end else if (tmo_hit) begin
                    take_tmo = 1'b1;
                    state_d  = RESP;
                end
            end
            RESP: begin
                rsp_valid[id_q] = 1'b1;
                if (bus.rsp_ready[id_q]) begin
                    rsp_hs  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand latch, watchdog counter, result capture and grant history
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            core_a_q     <= '0;
            core_b_q     <= '0;
            core_c_q     <= '0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
            id_q         <= '0;
            cnt_q        <= '0;
            last_grant_q <= ID_W'(NUM_REQ - 1);
        end else begin
            if (accept) begin
                core_a_q <= a_arr[pick_idx];
                core_b_q <= b_arr[pick_idx];
                core_c_q <= c_arr[pick_idx];
                id_q     <= pick_idx;
                cnt_q    <= '0;
            end else if (state_q == START || state_q == WAIT) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (take_done) begin
                rsp_data_q <= bus.core_return;
                rsp_err_q  <= 1'b0;
            end else if (take_tmo) begin
                rsp_data_q <= '0;
                rsp_err_q  <= 1'b1;
            end
            if (rsp_hs) last_grant_q <= id_q;
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.rsp_valid  = rsp_valid;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.core_start = core_start;
    assign bus.core_a     = core_a_q;
    assign bus.core_b     = core_b_q;
    assign bus.core_c     = core_c_q;
endmodule

// File: tb/tb_mul_share_arb.sv
// Directed bench for mul_share_arb with a small behavioural mul core.
module tb_mul_share_arb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    mul_share_arb_if #(.NUM_REQ(4), .DATA_W(32)) bus ();

    mul_share_arb #(
        .NUM_REQ (4),
        .DATA_W  (32),
        .TIMEOUT (16)
    ) dut (
        .ap_clk   (clk),
        .ap_rst_n (rst_n),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    // Requester operand tables
    logic [31:0] ta [4];
    logic [31:0] tb [4];
    logic [31:0] tc [4];
    for (genvar g = 0; g < 4; g++) begin : g_ops
        assign bus.req_a[g*32 +: 32] = ta[g];
        assign bus.req_b[g*32 +: 32] = tb[g];
        assign bus.req_c[g*32 +: 32] = tc[g];
    end

    // Core model: ready with start (after ready_hold cycles), done 3 cycles after start
    logic        pend = 1'b0;
    int unsigned dly = 0;
    int unsigned hold_cnt = 0;
    logic [31:0] ret_q = '0;
    logic        no_done = 1'b0;
    logic        stray_done = 1'b0;
    int unsigned ready_hold = 0;

    assign bus.core_ready  = bus.core_start && (hold_cnt >= ready_hold);
    assign bus.core_done   = (pend && dly == 0) || stray_done;
    assign bus.core_idle   = !pend;
    assign bus.core_return = ret_q;

    always @(posedge clk) begin
        if (bus.core_start && !bus.core_ready) hold_cnt <= hold_cnt + 1;
        else                                   hold_cnt <= 0;
        if (bus.core_start && bus.core_ready) begin
            if (!no_done) begin
                pend <= 1'b1;
                dly  <= 2;
            end
            ret_q <= bus.core_a * bus.core_b + bus.core_c;
        end else if (pend) begin
            if (dly == 0) pend <= 1'b0;
            else          dly  <= dly - 1;
        end
    end

    task automatic apply_reset();
        rst_n = 1'b0;
        bus.req_valid = '0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_valid = 4'b1111;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got %b want 0000", bus.req_ready); end
        checks++; if (bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid got %b want 0000", bus.rsp_valid); end
        checks++; if (bus.core_start !== 1'b0) begin errors++; $display("FAIL reset_core_start got %b want 0", bus.core_start); end
        checks++; if ({bus.core_a, bus.core_b, bus.core_c} !== 96'd0) begin errors++; $display("FAIL reset_core_ops got %h %h %h want 0", bus.core_a, bus.core_b, bus.core_c); end
        checks++; if (bus.rsp_data !== 32'd0 || bus.rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp got %h err %b want 0", bus.rsp_data, bus.rsp_err); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.req_valid = '0;
    endtask

    task automatic test_single();
        int unsigned first_rsp, starts;
        logic [3:0]  v;
        logic [31:0] d;
        logic        e;
        apply_reset();
        ta[0] = 32'd3; tb[0] = 32'd5; tc[0] = 32'd7;
        bus.req_valid = 4'b0001;
        @(negedge clk);
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL single_req_ready got %b want 0001", bus.req_ready); end
        @(posedge clk);
        #1 bus.req_valid = '0;
        first_rsp = 0; starts = 0; v = '0; d = '0; e = 1'b0;
        for (int unsigned n = 1; n <= 30 && first_rsp == 0; n++) begin
            @(negedge clk);
            if (bus.core_start) starts++;
            if (bus.rsp_valid != 0) begin
                first_rsp = n; v = bus.rsp_valid; d = bus.rsp_data; e = bus.rsp_err;
            end
        end
        checks++; if (first_rsp != 5) begin errors++; $display("FAIL single_latency got %0d want 5", first_rsp); end
        checks++; if (starts != 1) begin errors++; $display("FAIL single_start_cycles got %0d want 1", starts); end
        checks++; if (v !== 4'b0001) begin errors++; $display("FAIL single_rsp_valid got %b want 0001", v); end
        checks++; if (d !== 32'd22 || e !== 1'b0) begin errors++; $display("FAIL single_rsp_data got %0d err %b want 22 err 0", d, e); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_tab [4];
        logic [3:0]  exp_oh;
        logic        found;
        exp_tab[0] = 32'd300; exp_tab[1] = 32'd304; exp_tab[2] = 32'd308; exp_tab[3] = 32'd7;
        ta[0] = 32'd100; tb[0] = 32'd3; tc[0] = 32'd0;
        ta[1] = 32'd101; tb[1] = 32'd3; tc[1] = 32'd1;
        ta[2] = 32'd102; tb[2] = 32'd3; tc[2] = 32'd2;
        ta[3] = 32'h8000_0001; tb[3] = 32'd2; tc[3] = 32'd5;
        apply_reset();
        bus.req_valid = 4'b1111;
        for (int unsigned k = 0; k < 5; k++) begin
            found = 1'b0;
            for (int unsigned n = 0; n < 40 && !found; n++) begin
                @(negedge clk);
                if (bus.rsp_valid != 0) found = 1'b1;
            end
            exp_oh = 4'b0001 << (k % 4);
            checks++;
            if (!found) begin
                errors++; $display("FAIL rr_timeout txn %0d got no response want %b", k, exp_oh);
            end else if (bus.rsp_valid !== exp_oh || bus.rsp_data !== exp_tab[k % 4]) begin
                errors++; $display("FAIL rr_txn%0d got %b/%0d want %b/%0d", k, bus.rsp_valid, bus.rsp_data, exp_oh, exp_tab[k % 4]);
            end
            @(posedge clk);
            #1;
        end
        bus.req_valid = '0;
    endtask

    task automatic test_ready_stall();
        int unsigned starts, low_cnt;
        logic        op_bad, found;
        logic [3:0]  v;
        logic [31:0] d;
        ta[1] = 32'd7; tb[1] = 32'd6; tc[1] = 32'd1;
        ready_hold = 4;
        bus.req_valid = 4'b0010;
        @(negedge clk);
        checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL stall_req_ready got %b want 0010", bus.req_ready); end
        @(posedge clk);
        #1 bus.req_valid = '0;
        starts = 0; low_cnt = 0; op_bad = 1'b0; found = 1'b0; v = '0; d = '0;
        for (int unsigned n = 1; n <= 30 && !found; n++) begin
            @(negedge clk);
            if (bus.core_start) begin
                starts++;
                if (!bus.core_ready) low_cnt++;
            end
            if (bus.core_a !== 32'd7 || bus.core_b !== 32'd6 || bus.core_c !== 32'd1) op_bad = 1'b1;
            if (bus.rsp_valid != 0) begin found = 1'b1; v = bus.rsp_valid; d = bus.rsp_data; end
        end
        checks++; if (starts != 5) begin errors++; $display("FAIL stall_start_cycles got %0d want 5", starts); end
        checks++; if (low_cnt != 4) begin errors++; $display("FAIL stall_ready_low got %0d want 4", low_cnt); end
        checks++; if (op_bad !== 1'b0) begin errors++; $display("FAIL stall_operands got changed want stable 7/6/1"); end
        checks++; if (v !== 4'b0010 || d !== 32'd43) begin errors++; $display("FAIL stall_rsp got %b/%0d want 0010/43", v, d); end
        @(posedge clk);
        #1 ready_hold = 0;
    endtask

    task automatic test_timeout();
        int unsigned first_rsp;
        logic        bad;
        logic [3:0]  v;
        logic [31:0] d;
        logic        e, cs;
        no_done = 1'b1;
        ta[2] = 32'd9; tb[2] = 32'd9; tc[2] = 32'd9;
        bus.req_valid = 4'b0100;
        @(posedge clk);
        #1 bus.req_valid = '0;
        first_rsp = 0; v = '0; d = 32'hFFFF_FFFF; e = 1'b0; cs = 1'b1;
        for (int unsigned n = 1; n <= 40 && first_rsp == 0; n++) begin
            @(negedge clk);
            if (bus.rsp_valid != 0) begin
                first_rsp = n; v = bus.rsp_valid; d = bus.rsp_data; e = bus.rsp_err; cs = bus.core_start;
            end
        end
        checks++; if (first_rsp != 17) begin errors++; $display("FAIL tmo_latency got %0d want 17", first_rsp); end
        checks++; if (v !== 4'b0100) begin errors++; $display("FAIL tmo_rsp_valid got %b want 0100", v); end
        checks++; if (d !== 32'd0 || e !== 1'b1) begin errors++; $display("FAIL tmo_rsp got %h err %b want 0 err 1", d, e); end
        checks++; if (cs !== 1'b0) begin errors++; $display("FAIL tmo_core_start got %b want 0", cs); end
        @(posedge clk);
        #1 no_done = 1'b0;
        stray_done = 1'b1;
        @(posedge clk);
        #1 stray_done = 1'b0;
        bad = 1'b0;
        for (int unsigned n = 0; n < 4; n++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 4'b0000 || bus.core_start !== 1'b0) bad = 1'b1;
        end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL stray_done got activity want idle"); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic found, bad;
        ta[2] = 32'd11; tb[2] = 32'd11; tc[2] = 32'd11;
        bus.rsp_ready = 4'b1011;
        bus.req_valid = 4'b0100;
        @(posedge clk);
        #1 bus.req_valid = 4'b1011;
        found = 1'b0;
        for (int unsigned n = 1; n <= 30 && !found; n++) begin
            @(negedge clk);
            if (bus.rsp_valid != 0) found = 1'b1;
        end
        checks++; if (!found || bus.rsp_valid !== 4'b0100 || bus.rsp_data !== 32'd132) begin errors++; $display("FAIL b2b_first got %b/%0d want 0100/132", bus.rsp_valid, bus.rsp_data); end
        bad = 1'b0;
        for (int unsigned k = 0; k < 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.rsp_valid !== 4'b0100 || bus.rsp_data !== 32'd132 || bus.req_ready !== 4'b0000) bad = 1'b1;
        end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL b2b_hold got unstable response or req_ready want stable 0100/132 with no grant"); end
        @(posedge clk);
        #1 bus.rsp_ready = 4'b1111;
        @(posedge clk);
        @(negedge clk);
        checks++; if (bus.req_ready !== 4'b1000) begin errors++; $display("FAIL b2b_next_grant got %b want 1000", bus.req_ready); end
        @(posedge clk);
        #1 bus.req_valid = '0;
        found = 1'b0;
        for (int unsigned n = 1; n <= 30 && !found; n++) begin
            @(negedge clk);
            if (bus.rsp_valid != 0) found = 1'b1;
        end
        checks++; if (!found || bus.rsp_valid !== 4'b1000 || bus.rsp_data !== 32'd7) begin errors++; $display("FAIL b2b_second got %b/%0d want 1000/7", bus.rsp_valid, bus.rsp_data); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_in_wait();
        logic       found, rsp_seen;
        logic [3:0] rr;
        bus.req_valid = 4'b1000;
        @(posedge clk);
        #1 bus.req_valid = '0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.req_valid = 4'b1111;
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 4'b0000 || bus.core_start !== 1'b0 || bus.req_ready !== 4'b0000) begin errors++; $display("FAIL rstwait_ctrl got rv %b cs %b rr %b want 0", bus.rsp_valid, bus.core_start, bus.req_ready); end
        checks++; if ({bus.core_a, bus.core_b, bus.core_c, bus.rsp_data} !== 128'd0 || bus.rsp_err !== 1'b0) begin errors++; $display("FAIL rstwait_data got %h %h %h %h want 0", bus.core_a, bus.core_b, bus.core_c, bus.rsp_data); end
        found = 1'b0; rsp_seen = 1'b0; rr = '0;
        for (int unsigned n = 0; n < 20 && !found; n++) begin
            @(negedge clk);
            if (bus.rsp_valid != 0) rsp_seen = 1'b1;
            if (bus.req_ready != 0) begin found = 1'b1; rr = bus.req_ready; end
        end
        checks++; if (rsp_seen !== 1'b0) begin errors++; $display("FAIL rstwait_no_rsp got response want none"); end
        checks++; if (!found || rr !== 4'b0001) begin errors++; $display("FAIL rstwait_grant got %b want 0001", rr); end
        @(posedge clk);
        #1 bus.req_valid = '0;
        found = 1'b0;
        for (int unsigned n = 1; n <= 30 && !found; n++) begin
            @(negedge clk);
            if (bus.rsp_valid != 0) found = 1'b1;
        end
        checks++; if (!found || bus.rsp_valid !== 4'b0001 || bus.rsp_data !== 32'd300) begin errors++; $display("FAIL rstwait_rsp got %b/%0d want 0001/300", bus.rsp_valid, bus.rsp_data); end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            ta[i] = '0; tb[i] = '0; tc[i] = '0;
        end
        bus.req_valid = '0;
        bus.rsp_ready = 4'b1111;
        test_reset();
        test_single();
        test_round_robin();
        test_ready_stall();
        test_timeout();
        test_back_to_back();
        test_reset_in_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
